// File: rtl/disp_pkg.sv
// ============================================================================
// Module      : disp_pkg
// Description : Shared constants, scan-state enum and BCD-to-segment lookup
//               for the seven-segment display scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package disp_pkg;

    // Active-low pin patterns
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [3:0] AN_OFF   = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_2x4.sv
// ============================================================================
// Module      : decoder_2x4
// Description : 2-to-4 one-hot decoder (active-high outputs).
// Ports       : sel_i    [1:0] binary select
//               onehot_o [3:0] one-hot result, bit sel_i set
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_2x4 (
    input  logic [1:0] sel_i,
    output logic [3:0] onehot_o
);

    always_comb begin
        onehot_o = 4'b0001 << sel_i;
    end

endmodule

`default_nettype wire

// File: rtl/seg7_encode.sv
// ============================================================================
// Module      : seg7_encode
// Description : Combinational BCD to active-low seven-segment encoder.
// Ports       : bcd_i    [3:0] BCD digit (10-15 render as a dash)
//               seg_n_o  [6:0] segments {g,f,e,d,c,b,a}, active-low
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_encode
    import disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_n_o
);

    assign seg_n_o = bcd_to_seg(bcd_i);

endmodule

`default_nettype wire

// File: rtl/display_scan_ctrl.sv
// ============================================================================
// Module      : display_scan_ctrl
// Description : Time-multiplexed scan controller for a 4-digit common-anode
//               seven-segment display. Each digit slot is REFRESH_DIV cycles:
//               BLANK_CYCLES with all anodes off (anti-ghosting), then the
//               selected anode driven. Digit data is latched at slot start.
// Ports       : clk          system clock
//               rst_n        synchronous active-low reset
//               en           scan enable (0 = dark, restart at digit 0)
//               digits_in    four BCD digits, [3:0] = rightmost
//               dp_in        decimal point request per digit
//               blank_in     force digit dark
//               lz_suppress  leading-zero suppression enable
//               an_n         anodes, active-low
//               seg_n        segments {g,f,e,d,c,b,a}, active-low
//               dp_n         decimal point, active-low
//               frame_done   one-cycle pulse after the digit 3 slot ends
// Options     : DISPLAY_SCAN_DP_BLINK_EN - blink the decimal point, toggling
//               every BLINK_FRAMES frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    input  logic        lz_suppress,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] C_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);

    scan_state_e      state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dark_q, dark_d;
    logic [3:0]       an_n_q, an_n_d;
    logic [6:0]       seg_n_q, seg_n_d;
    logic             dp_n_q, dp_n_d;
    logic             frame_done_q, frame_done_d;

    logic [1:0]       w_entry_idx;
    logic [3:0]       w_entry_digit;
    logic [6:0]       w_entry_seg;
    logic             w_entry_lz_dark;
    logic [3:0]       w_onehot;
    logic             w_phase_next;

    // A slot is only ever entered from IDLE (digit 0) or from the end of the
    // previous DRIVE, so the entering index is known without the FSM output.
    assign w_entry_idx   = (state_q == DRIVE) ? (idx_q + 2'd1) : 2'd0;
    assign w_entry_digit = digits_in[{w_entry_idx, 2'b00} +: 4];

    seg7_encode u_seg7_encode (
        .bcd_i   (w_entry_digit),
        .seg_n_o (w_entry_seg)
    );

    decoder_2x4 u_decoder_2x4 (
        .sel_i    (idx_q),
        .onehot_o (w_onehot)
    );

    // A digit is a leading zero when it and every more-significant digit is 0.
    always_comb begin
        w_entry_lz_dark = 1'b0;
        case (w_entry_idx)
            2'd3:    w_entry_lz_dark = (digits_in[15:12] == 4'd0);
            2'd2:    w_entry_lz_dark = (digits_in[15:8]  == 8'd0);
            2'd1:    w_entry_lz_dark = (digits_in[15:4]  == 12'd0);
            default: w_entry_lz_dark = 1'b0;
        endcase
        w_entry_lz_dark = w_entry_lz_dark & lz_suppress;
    end

`ifdef DISPLAY_SCAN_DP_BLINK_EN
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] C_BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic               w_frame_end;

    assign w_frame_end = en && (state_q == DRIVE) && (idx_q == 2'd3)
                         && (cnt_q == C_SLOT_LAST);

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (!en) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (w_frame_end) begin
            if (blink_cnt_q == C_BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    // Next phase, so a slot starting on a frame boundary sees the new phase.
    assign w_phase_next = phase_d;
`else
    // No blinking: the point follows dp_in; the blink period has no effect.
    assign w_phase_next = (BLINK_FRAMES >= 0) | 1'b1;
`endif

    // Next-state and registered-output logic. Outputs are computed for the
    // state being entered so they line up with state_q after the edge.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        dark_d       = dark_q;
        an_n_d       = AN_OFF;
        seg_n_d      = seg_n_q;
        dp_n_d       = dp_n_q;
        frame_done_d = 1'b0;

        if (!en) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
            seg_n_d = SEG_OFF;
            dp_n_d  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == C_BLANK_LAST) begin
                        state_d = DRIVE;
                        an_n_d  = dark_q ? AN_OFF : ~w_onehot;
                    end
                end
                DRIVE: begin
                    if (cnt_q == C_SLOT_LAST) begin
                        state_d      = BLANK;
                        cnt_d        = '0;
                        idx_d        = w_entry_idx;
                        frame_done_d = (idx_q == 2'd3);
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        an_n_d = dark_q ? AN_OFF : ~w_onehot;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    seg_n_d = SEG_OFF;
                    dp_n_d  = 1'b1;
                end
            endcase

            // Slot entry: latch this digit's glyph, point and darkness.
            if (state_d == BLANK && state_q != BLANK) begin
                seg_n_d = w_entry_seg;
                dp_n_d  = ~(dp_in[w_entry_idx] & w_phase_next);
                dark_d  = blank_in[w_entry_idx] | w_entry_lz_dark;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            dark_q       <= 1'b0;
            an_n_q       <= AN_OFF;
            seg_n_q      <= SEG_OFF;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            dark_q       <= dark_d;
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an_n       = an_n_q;
    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
// ============================================================================
// Module      : tb_display_scan_ctrl
// Description : Self-checking bench for display_scan_ctrl with a cycle-level
//               reference model based on elapsed time since scan start.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_scan_ctrl;

    localparam int RD = 8;
    localparam int BC = 2;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lz_suppress;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    // Reference model: m_t counts cycles since the first BLANK of the scan.
    bit         m_run = 1'b0;
    int         m_t   = 0;
    logic [6:0] m_seg = 7'h7F;
    bit         m_dark = 1'b0;
    bit         m_dp   = 1'b0;
    bit         m_fd   = 1'b0;

    display_scan_ctrl #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .lz_suppress (lz_suppress),
        .an_n        (an_n),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;  4'd1: return 7'h79;
            4'd2: return 7'h24;  4'd3: return 7'h30;
            4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;
            4'd8: return 7'h00;  4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    task automatic snap();
        int  i;
        bit  hz;
        i  = (m_t / RD) % 4;
        hz = 1'b1;
        for (int j = i; j < 4; j++)
            if (digits_in[j*4 +: 4] != 4'd0) hz = 1'b0;
        m_seg  = glyph(digits_in[i*4 +: 4]);
        m_dp   = dp_in[i];
        m_dark = blank_in[i] | (lz_suppress & (i > 0) & hz);
    endtask

    function automatic bit phase();
        int f;
        f = m_t / (4 * RD);
`ifdef DISPLAY_SCAN_DP_BLINK_EN
        return ((f / BF) % 2) == 0;
`else
        return (f >= 0);
`endif
    endfunction

    function automatic logic [3:0] exp_an();
        logic [3:0] a;
        int idx;
        idx = (m_t / RD) % 4;
        if (!m_run || (m_t % RD) < BC || m_dark) return 4'hF;
        a = 4'b0001 << idx;
        return ~a;
    endfunction

    function automatic logic [6:0] exp_seg();
        return m_run ? m_seg : 7'h7F;
    endfunction

    function automatic logic exp_dp();
        return m_run ? ~(m_dp & phase()) : 1'b1;
    endfunction

    // Advance the model over one clock edge using the inputs now applied.
    task automatic tick();
        if (!rst_n || !en) begin
            m_run = 1'b0;
            m_t   = 0;
            m_fd  = 1'b0;
        end else begin
            if (!m_run) begin
                m_run = 1'b1;
                m_t   = 0;
            end else begin
                m_t++;
            end
            if (m_t % RD == 0) snap();
            m_fd = (m_t > 0) && (m_t % (4 * RD) == 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; digits_in = 16'h1234;
        dp_in = 4'h0; blank_in = 4'h0; lz_suppress = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({an_n, seg_n, dp_n, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL reset_hold got an=%h seg=%h dp=%b fd=%b want an=f seg=7f dp=1 fd=0",
                         an_n, seg_n, dp_n, frame_done);
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({an_n, seg_n, dp_n, frame_done} !== {exp_an(), exp_seg(), exp_dp(), m_fd}) begin
                bad++;
                $display("FAIL reset_model t=%0d got an=%h seg=%h dp=%b fd=%b want an=%h seg=%h dp=%b fd=%b",
                         m_t, an_n, seg_n, dp_n, frame_done, exp_an(), exp_seg(), exp_dp(), m_fd);
            end
        end
        total++;
        if (an_n !== 4'hE) begin
            bad++;
            $display("FAIL reset_first_drive got an=%h want an=e", an_n);
        end
    endtask

    task automatic test_scan();
        int fd_cnt;
        int an_cnt[4];
        fd_cnt = 0;
        for (int k = 0; k < 4; k++) an_cnt[k] = 0;
        for (int k = 0; k < 64; k++) begin
            tick();
            total++;
            if ({an_n, seg_n, dp_n, frame_done} !== {exp_an(), exp_seg(), exp_dp(), m_fd}) begin
                bad++;
                $display("FAIL scan t=%0d got an=%h seg=%h dp=%b fd=%b want an=%h seg=%h dp=%b fd=%b",
                         m_t, an_n, seg_n, dp_n, frame_done, exp_an(), exp_seg(), exp_dp(), m_fd);
            end
            if (frame_done === 1'b1) fd_cnt++;
            if (an_n === 4'hE && seg_n === 7'h19) an_cnt[0]++;
            if (an_n === 4'hD && seg_n === 7'h30) an_cnt[1]++;
            if (an_n === 4'hB && seg_n === 7'h24) an_cnt[2]++;
            if (an_n === 4'h7 && seg_n === 7'h79) an_cnt[3]++;
        end
        total++;
        if (fd_cnt != 2) begin
            bad++;
            $display("FAIL scan_frame_done got %0d pulses want 2", fd_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (an_cnt[k] != 12) begin
                bad++;
                $display("FAIL scan_digit%0d_cycles got %0d want 12", k, an_cnt[k]);
            end
        end
    endtask

    task automatic test_lz();
        int lit;
        lz_suppress = 1'b1; digits_in = 16'h0005;
        lit = 0;
        for (int k = 0; k < 72; k++) begin
            tick();
            total++;
            if ({an_n, seg_n, dp_n, frame_done} !== {exp_an(), exp_seg(), exp_dp(), m_fd}) begin
                bad++;
                $display("FAIL lz t=%0d got an=%h seg=%h dp=%b fd=%b want an=%h seg=%h dp=%b fd=%b",
                         m_t, an_n, seg_n, dp_n, frame_done, exp_an(), exp_seg(), exp_dp(), m_fd);
            end
            if (k >= 40 && an_n !== 4'hF) begin
                lit++;
                total++;
                if (an_n !== 4'hE || seg_n !== 7'h12) begin
                    bad++;
                    $display("FAIL lz_lit got an=%h seg=%h want an=e seg=12", an_n, seg_n);
                end
            end
        end
        total++;
        if (lit != 6) begin
            bad++;
            $display("FAIL lz_lit_cycles got %0d want 6", lit);
        end
    endtask

    task automatic test_dash();
        int dash;
        lz_suppress = 1'b0; digits_in = 16'h00A0;
        dash = 0;
        for (int k = 0; k < 72; k++) begin
            tick();
            total++;
            if ({an_n, seg_n, dp_n, frame_done} !== {exp_an(), exp_seg(), exp_dp(), m_fd}) begin
                bad++;
                $display("FAIL dash t=%0d got an=%h seg=%h dp=%b fd=%b want an=%h seg=%h dp=%b fd=%b",
                         m_t, an_n, seg_n, dp_n, frame_done, exp_an(), exp_seg(), exp_dp(), m_fd);
            end
            if (k >= 40 && an_n === 4'hD && seg_n === 7'h3F) dash++;
        end
        total++;
        if (dash != 6) begin
            bad++;
            $display("FAIL dash_cycles got %0d want 6", dash);
        end
    endtask

    task automatic test_en_drop();
        int guard;
        guard = 0;
        while (!(m_run && (m_t % (4 * RD)) == 2 * RD + 4) && guard < 80) begin
            tick();
            guard++;
        end
        total++;
        if (guard >= 80) begin
            bad++;
            $display("FAIL en_drop_timeout got %0d cycles want <80", guard);
        end
        en = 1'b0;
        tick();
        total++;
        if ({an_n, seg_n, dp_n, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL en_drop_dark got an=%h seg=%h dp=%b fd=%b want an=f seg=7f dp=1 fd=0",
                     an_n, seg_n, dp_n, frame_done);
        end
        tick();
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({an_n, seg_n, dp_n, frame_done} !== {exp_an(), exp_seg(), exp_dp(), m_fd}) begin
                bad++;
                $display("FAIL en_restart t=%0d got an=%h seg=%h dp=%b fd=%b want an=%h seg=%h dp=%b fd=%b",
                         m_t, an_n, seg_n, dp_n, frame_done, exp_an(), exp_seg(), exp_dp(), m_fd);
            end
        end
        total++;
        if (an_n !== 4'hE || seg_n !== 7'h40) begin
            bad++;
            $display("FAIL en_restart_digit0 got an=%h seg=%h want an=e seg=40", an_n, seg_n);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                for (int n = 0; n < 4; n++)
                    digits_in[n*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                dp_in       = 4'($urandom);
                blank_in    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                lz_suppress = 1'($urandom);
            end
            en    = ($urandom_range(0, 59) != 0);
            rst_n = ($urandom_range(0, 149) != 0);
            tick();
            total++;
            if ({an_n, seg_n, dp_n, frame_done} !== {exp_an(), exp_seg(), exp_dp(), m_fd}) begin
                bad++;
                $display("FAIL random t=%0d got an=%h seg=%h dp=%b fd=%b want an=%h seg=%h dp=%b fd=%b",
                         m_t, an_n, seg_n, dp_n, frame_done, exp_an(), exp_seg(), exp_dp(), m_fd);
            end
        end
        rst_n = 1'b1;
        en    = 1'b1;
    endtask

    task automatic test_blink();
        logic want;
        int   f;
        en = 1'b0; dp_in = 4'b0100; blank_in = 4'h0;
        lz_suppress = 1'b0; digits_in = 16'h9876;
        tick();
        en = 1'b1;
        for (int k = 0; k < 5 * 4 * RD; k++) begin
            tick();
            total++;
            if ({an_n, seg_n, dp_n, frame_done} !== {exp_an(), exp_seg(), exp_dp(), m_fd}) begin
                bad++;
                $display("FAIL blink t=%0d got an=%h seg=%h dp=%b fd=%b want an=%h seg=%h dp=%b fd=%b",
                         m_t, an_n, seg_n, dp_n, frame_done, exp_an(), exp_seg(), exp_dp(), m_fd);
            end
            if (m_t % (4 * RD) == 2 * RD + 4) begin
                f = m_t / (4 * RD);
`ifdef DISPLAY_SCAN_DP_BLINK_EN
                want = ((f % 4) < 2) ? 1'b0 : 1'b1;
`else
                want = 1'b0;
`endif
                total++;
                if (dp_n !== want || an_n !== 4'hB) begin
                    bad++;
                    $display("FAIL blink_slot2 frame=%0d got dp=%b an=%h want dp=%b an=b",
                             f, dp_n, an_n, want);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lz();
        test_dash();
        test_en_drop();
        test_random();
        test_blink();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
